cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
//
// PURPOSE
// Parametrised common-data-bus arbiter and broadcast register for the fcpu out-of-order core.
// Collects result packets {rsv_id, data} from N functional units (ALU, MFU, MMU, ...).
// Grants one per cycle, by fixed-priority or round-robin selection.
// Broadcasts the winner one cycle later on a registered cdb/cdb_valid pair.
// Consumers of that pair: reservation stations, ROB, register-file bypass.
// Replaces the inline combinational priority mux in the core top level.
//
// PARAMETERS
// N_UNITS   3       number of requesting functional units (>=1)
// CDB_W     CDB_W   packet width, fcpu_pkg value (RSV_ID_W+DATA_W)
// RR_MODE   0       0: fixed priority, lowest index wins; 1: round-robin
// CNT_W     32      width of broadcast-cycle performance counter
//
// PORTS
// clk         in   1                 core clock
// nrst        in   1                 asynchronous active-low reset
// i_cdb       in   N_UNITS*CDB_W     per-unit result packet, unit k at [k*CDB_W+:CDB_W]
// i_valid     in   N_UNITS           per-unit request
// i_ready     out  N_UNITS           per-unit grant; transfer when i_valid[k]&i_ready[k]
// flush       in   1                 branch miss: drop this cycle's arbitration
// cdb         out  CDB_W             registered broadcast packet
// cdb_valid   out  1                 registered broadcast valid
// grant_id    out  GID_W             index of unit whose packet is on cdb
//                                    GID_W = max(1,$clog2(N_UNITS))
// busy_cnt    out  CNT_W             saturating count of cycles with cdb_valid=1
//
// BEHAVIOUR
// - Reset (nrst=0, async) clears: cdb, cdb_valid, grant_id, busy_cnt, RR pointer ptr.
//   i_ready is all-zero while nrst=0.
// - Handshake: i_ready is combinational from i_valid, ptr and flush only.
//   It never depends on i_cdb. At most one bit is set per cycle.
//   A unit holds i_valid and i_cdb stable until granted; it never withdraws a request.
// - Winner, fixed mode: lowest k with i_valid[k].
// - Winner, RR mode: first k with i_valid[k], searching ptr, ptr+1, ... N_UNITS-1, 0, ... ptr-1.
// - On a grant (any valid bit, flush=0), at the next edge:
//   - cdb <= i_cdb[winner]; cdb_valid <= 1; grant_id <= winner.
//   - RR mode: ptr <= (winner==N_UNITS-1) ? 0 : winner+1.
//   - Latency is exactly 1 cycle, with back-to-back grants every cycle.
// - No request: cdb <= 0, cdb_valid <= 0, grant_id holds, ptr holds.
// - flush=1: i_ready=0 for all units; cdb <= 0 and cdb_valid <= 0 next edge; ptr holds.
//   A packet registered before the flush cycle is still visible during that cycle.
// - busy_cnt increments on every edge where cdb_valid (current) is 1.
//   It saturates at all-ones and never wraps.
// - N_UNITS=1: unit 0 is always the winner; ptr is constant 0.
// - Fixed mode ignores ptr; the ptr register is still present and stays 0.
//
// TESTING
// 1. Fixed, N=3, i_valid=111 held, packets 0xA/0xB/0xC
//    -> i_ready=001 every cycle; cdb=0xA, cdb_valid=1 from cycle 1.
// 2. RR, N=3, i_valid=111 for 4 cycles
//    -> grants 0,1,2,0; cdb/grant_id follow one cycle later; ptr ends at 1.
// 3. RR, ptr=2, i_valid=001
//    -> i_ready=001 (wrap search); next cycle grant_id=0 and ptr=1.
// 4. RR, i_valid=111 with flush=1 for one cycle
//    -> i_ready=000; next cycle cdb_valid=0, cdb=0; ptr unchanged; then arbitration resumes.
// 5. Assert nrst mid-stream with i_valid=110
//    -> cdb, cdb_valid, busy_cnt go 0 without a clock edge.
//    After release: RR grants unit 1 first, since ptr=0 and unit 0 is idle.
// 6. 10 consecutive grants, then idle -> busy_cnt=10.
//    With CNT_W=2: busy_cnt sticks at 3.

Source files
------------

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Common-data-bus arbiter and broadcast register for the fcpu out-of-order core.
// Each cycle, one of N_UNITS result packets {rsv_id, data} is granted. The
// selection is either fixed priority (lowest index wins) or round-robin. The
// winning packet is broadcast one cycle later on a registered cdb/cdb_valid
// pair, which feeds the reservation stations, the ROB and the register-file
// bypass.
//
// Parameters
//   N_UNITS  number of requesting functional units (>= 1)
//   CDB_W    packet width (RSV_ID_W + DATA_W)
//   RR_MODE  0: fixed priority, lowest index wins; 1: round-robin
//   CNT_W    width of the saturating broadcast-cycle counter
//
// Ports
//   clk        core clock
//   nrst       asynchronous active-low reset
//   i_cdb      per-unit packet; unit k is at [k*CDB_W +: CDB_W]
//   i_valid    per-unit request; a unit holds it until it is granted
//   i_ready    per-unit grant (one-hot or zero); combinational from
//              i_valid, the RR pointer and flush only
//   flush      branch miss; drops this cycle's arbitration
//   cdb        registered broadcast packet (zero when idle)
//   cdb_valid  registered broadcast valid
//   grant_id   index of the unit whose packet is on cdb; holds when idle
//   busy_cnt   saturating count of cycles with cdb_valid = 1
// -----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int  N_UNITS = 3,
   parameter int  CDB_W   = 40,
   parameter int  RR_MODE = 0,
   parameter int  CNT_W   = 32,
   localparam int GID_W   = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic [N_UNITS*CDB_W-1:0] i_cdb,
   input  logic [N_UNITS-1:0]       i_valid,
   output logic [N_UNITS-1:0]       i_ready,
   input  logic                     flush,
   output logic [CDB_W-1:0]         cdb,
   output logic                     cdb_valid,
   output logic [GID_W-1:0]         grant_id,
   output logic [CNT_W-1:0]         busy_cnt
);

   logic [GID_W-1:0]   r_ptr;
   logic [CDB_W-1:0]   r_cdb;
   logic               r_cdb_valid;
   logic [GID_W-1:0]   r_gid;
   logic [CNT_W-1:0]   r_busy;

   logic [N_UNITS-1:0] w_req;
   logic [N_UNITS-1:0] w_gnt;
   logic               w_any;
   logic [GID_W-1:0]   w_win;
   logic [GID_W-1:0]   w_ptr_nxt;
   logic [CDB_W-1:0]   w_pkt;

   always_comb begin : arb
      int unsigned ptr_u;
      ptr_u = 32'(r_ptr);
      w_req = flush ? '0 : i_valid;
      w_any = |w_req;
      w_win = '0;
      // Both scans run from high to low index, so the lowest matching index
      // is the last one written. The second scan only covers indices at or
      // above ptr. If it finds a request, it overrides the first scan. This
      // gives the wrapped search ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
      for (int unsigned k = N_UNITS; k > 0; k--) begin
         if (w_req[k-1]) w_win = GID_W'(k-1);
      end
      if (RR_MODE != 0) begin
         for (int unsigned k = N_UNITS; k > 0; k--) begin
            if (w_req[k-1] && ((k-1) >= ptr_u)) w_win = GID_W'(k-1);
         end
      end

      w_gnt = '0;
      w_pkt = '0;
      for (int unsigned k = 0; k < N_UNITS; k++) begin
         if (w_any && (32'(w_win) == k)) begin
            w_gnt[k] = 1'b1;
            w_pkt    = i_cdb[k*CDB_W +: CDB_W];
         end
      end

      // In fixed mode the pointer is never advanced, so it stays at zero.
      w_ptr_nxt = r_ptr;
      if ((RR_MODE != 0) && w_any) begin
         w_ptr_nxt = (32'(w_win) == 32'(N_UNITS - 1)) ? '0 : w_win + GID_W'(1);
      end
   end

   assign i_ready = nrst ? w_gnt : '0;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_ptr       <= '0;
         r_cdb       <= '0;
         r_cdb_valid <= 1'b0;
         r_gid       <= '0;
         r_busy      <= '0;
      end else begin
         if (w_any) begin
            r_cdb       <= w_pkt;
            r_cdb_valid <= 1'b1;
            r_gid       <= w_win;
         end else begin
            r_cdb       <= '0;
            r_cdb_valid <= 1'b0;
         end
         r_ptr <= w_ptr_nxt;
         if (r_cdb_valid && (r_busy != '1)) r_busy <= r_busy + CNT_W'(1);
      end
   end

   assign cdb       = r_cdb;
   assign cdb_valid = r_cdb_valid;
   assign grant_id  = r_gid;
   assign busy_cnt  = r_busy;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

   localparam int W = 8;

   logic clk = 1'b0;
   logic nrst = 1'b1;
   logic flush = 1'b0;
   logic [2:0]     vin [3];
   logic [3*W-1:0] pin [3];

   logic [2:0]  rdy_fx, rdy_rr;
   logic        rdy_one;
   logic [W-1:0] c_fx, c_rr, c_one;
   logic        v_fx, v_rr, v_one;
   logic [1:0]  g_fx, g_rr;
   logic        g_one;
   logic [31:0] b_fx;
   logic [1:0]  b_rr;
   logic [2:0]  b_one;

   always #5 clk = ~clk;

   cdb_arbiter #(.N_UNITS(3), .CDB_W(W), .RR_MODE(0), .CNT_W(32)) dut_fx (
      .clk(clk), .nrst(nrst), .i_cdb(pin[0]), .i_valid(vin[0]), .i_ready(rdy_fx),
      .flush(flush), .cdb(c_fx), .cdb_valid(v_fx), .grant_id(g_fx), .busy_cnt(b_fx));

   cdb_arbiter #(.N_UNITS(3), .CDB_W(W), .RR_MODE(1), .CNT_W(2)) dut_rr (
      .clk(clk), .nrst(nrst), .i_cdb(pin[1]), .i_valid(vin[1]), .i_ready(rdy_rr),
      .flush(flush), .cdb(c_rr), .cdb_valid(v_rr), .grant_id(g_rr), .busy_cnt(b_rr));

   cdb_arbiter #(.N_UNITS(1), .CDB_W(W), .RR_MODE(1), .CNT_W(3)) dut_one (
      .clk(clk), .nrst(nrst), .i_cdb(pin[2][W-1:0]), .i_valid(vin[2][0]), .i_ready(rdy_one),
      .flush(flush), .cdb(c_one), .cdb_valid(v_one), .grant_id(g_one), .busy_cnt(b_one));

   // reference model: one entry per instance (0 fixed/3, 1 rr/3, 2 rr/1)
   int          n_u  [3] = '{3, 3, 1};
   bit          rr_m [3] = '{1'b0, 1'b1, 1'b1};
   longint unsigned cmax [3] = '{64'hFFFF_FFFF, 64'd3, 64'd7};
   int          m_ptr [3];
   logic [W-1:0] m_cdb [3];
   bit          m_v   [3];
   int          m_gid [3];
   longint unsigned m_busy [3];
   int          lastw [3];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] actual=%0h expected=%0h at %0t", name, d, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] o_rdy(input int d);
      case (d)
         0: return 64'(rdy_fx);
         1: return 64'(rdy_rr);
         default: return 64'(rdy_one);
      endcase
   endfunction
   function automatic logic [63:0] o_cdb(input int d);
      case (d)
         0: return 64'(c_fx);
         1: return 64'(c_rr);
         default: return 64'(c_one);
      endcase
   endfunction
   function automatic logic [63:0] o_v(input int d);
      case (d)
         0: return 64'(v_fx);
         1: return 64'(v_rr);
         default: return 64'(v_one);
      endcase
   endfunction
   function automatic logic [63:0] o_gid(input int d);
      case (d)
         0: return 64'(g_fx);
         1: return 64'(g_rr);
         default: return 64'(g_one);
      endcase
   endfunction
   function automatic logic [63:0] o_busy(input int d);
      case (d)
         0: return 64'(b_fx);
         1: return 64'(b_rr);
         default: return 64'(b_one);
      endcase
   endfunction

   // Winner: the first requesting unit in search order, or -1 if there is none.
   function automatic int winner(input logic [2:0] v, input int p, input int n, input bit rr);
      for (int i = 0; i < n; i++) begin
         int k;
         k = rr ? (p + i) % n : i;
         if (v[k] === 1'b1) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_ptr[d] = 0; m_cdb[d] = '0; m_v[d] = 0; m_gid[d] = 0; m_busy[d] = 0;
      end
   endtask

   // Entered just after a rising edge, with the inputs already driven.
   task automatic step();
      int w [3];
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         w[d] = flush ? -1 : winner(vin[d], m_ptr[d], n_u[d], rr_m[d]);
         chk("ready", d, o_rdy(d), (w[d] < 0) ? 64'd0 : (64'd1 << w[d]));
         chk("cdb_valid_hold", d, o_v(d), 64'(m_v[d]));
         chk("cdb_hold", d, o_cdb(d), 64'(m_cdb[d]));
      end
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         if (m_v[d] && m_busy[d] < cmax[d]) m_busy[d]++;
         if (w[d] >= 0) begin
            m_cdb[d] = pin[d][w[d]*W +: W];
            m_v[d]   = 1;
            m_gid[d] = w[d];
            if (rr_m[d]) m_ptr[d] = (m_ptr[d] + 0 == 0 && n_u[d] == 1) ? 0 : (w[d] + 1) % n_u[d];
         end else begin
            m_cdb[d] = '0;
            m_v[d]   = 0;
         end
         lastw[d] = w[d];
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("cdb", d, o_cdb(d), 64'(m_cdb[d]));
         chk("cdb_valid", d, o_v(d), 64'(m_v[d]));
         chk("grant_id", d, o_gid(d), 64'(m_gid[d]));
         chk("busy_cnt", d, o_busy(d), 64'(m_busy[d]));
      end
   endtask

   // Entered just after a rising edge. Reset is asserted between edges.
   task automatic do_reset();
      #2 nrst = 1'b0;
      #1;
      model_reset();
      for (int d = 0; d < 3; d++) begin
         chk("rst_cdb", d, o_cdb(d), 64'd0);
         chk("rst_valid", d, o_v(d), 64'd0);
         chk("rst_gid", d, o_gid(d), 64'd0);
         chk("rst_busy", d, o_busy(d), 64'd0);
         chk("rst_ready", d, o_rdy(d), 64'd0);
      end
      @(posedge clk);
      #1 nrst = 1'b1;
   endtask

   task automatic set_all(input logic [2:0] v, input logic f);
      for (int d = 0; d < 3; d++) vin[d] = v;
      flush = f;
   endtask

   typedef struct {
      logic [2:0]   v;
      logic         fl;
      logic [2:0]   rfx, rrr;
      logic [W-1:0] cfx, crr;
      logic [1:0]   gfx, grr;
      logic         cv;
   } vec_t;

   vec_t tbl [12];
   bit pend [3][3];

   initial begin
      tbl[0]  = '{3'b111, 1'b0, 3'b001, 3'b001, 8'h0A, 8'h0A, 2'd0, 2'd0, 1'b1};
      tbl[1]  = '{3'b111, 1'b0, 3'b001, 3'b010, 8'h0A, 8'h0B, 2'd0, 2'd1, 1'b1};
      tbl[2]  = '{3'b111, 1'b0, 3'b001, 3'b100, 8'h0A, 8'h0C, 2'd0, 2'd2, 1'b1};
      tbl[3]  = '{3'b111, 1'b0, 3'b001, 3'b001, 8'h0A, 8'h0A, 2'd0, 2'd0, 1'b1};
      tbl[4]  = '{3'b111, 1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 2'd0, 2'd0, 1'b0};
      tbl[5]  = '{3'b111, 1'b0, 3'b001, 3'b010, 8'h0A, 8'h0B, 2'd0, 2'd1, 1'b1};
      tbl[6]  = '{3'b001, 1'b0, 3'b001, 3'b001, 8'h0A, 8'h0A, 2'd0, 2'd0, 1'b1};
      tbl[7]  = '{3'b100, 1'b0, 3'b100, 3'b100, 8'h0C, 8'h0C, 2'd2, 2'd2, 1'b1};
      tbl[8]  = '{3'b000, 1'b0, 3'b000, 3'b000, 8'h00, 8'h00, 2'd2, 2'd2, 1'b0};
      tbl[9]  = '{3'b110, 1'b0, 3'b010, 3'b010, 8'h0B, 8'h0B, 2'd1, 2'd1, 1'b1};
      tbl[10] = '{3'b011, 1'b0, 3'b001, 3'b001, 8'h0A, 8'h0A, 2'd0, 2'd0, 1'b1};
      tbl[11] = '{3'b011, 1'b0, 3'b001, 3'b010, 8'h0A, 8'h0B, 2'd0, 2'd1, 1'b1};

      for (int d = 0; d < 3; d++) begin
         vin[d] = '0;
         pin[d] = {8'h0C, 8'h0B, 8'h0A};
      end
      model_reset();
      do_reset();

      // table-driven directed vectors
      for (int i = 0; i < 12; i++) begin
         set_all(tbl[i].v, tbl[i].fl);
         #1;
         chk("tbl_rdy_fx", i, 64'(rdy_fx), 64'(tbl[i].rfx));
         chk("tbl_rdy_rr", i, 64'(rdy_rr), 64'(tbl[i].rrr));
         step();
         chk("tbl_cdb_fx", i, 64'(c_fx), 64'(tbl[i].cfx));
         chk("tbl_cdb_rr", i, 64'(c_rr), 64'(tbl[i].crr));
         chk("tbl_gid_fx", i, 64'(g_fx), 64'(tbl[i].gfx));
         chk("tbl_gid_rr", i, 64'(g_rr), 64'(tbl[i].grr));
         chk("tbl_cv", i, 64'(v_rr), 64'(tbl[i].cv));
      end

      // asynchronous reset mid-stream, then RR must pick unit 1 first
      set_all(3'b110, 1'b0);
      step();
      step();
      do_reset();
      step();
      chk("post_rst_gid_rr", 0, 64'(g_rr), 64'd1);
      chk("post_rst_cdb_rr", 0, 64'(c_rr), 64'h0B);

      // ten back-to-back grants, then idle: counter reaches 10 / saturates
      do_reset();
      set_all(3'b001, 1'b0);
      for (int i = 0; i < 10; i++) step();
      set_all(3'b000, 1'b0);
      step();
      step();
      chk("busy10_fx", 0, 64'(b_fx), 64'd10);
      chk("busy_sat_rr", 1, 64'(b_rr), 64'd3);
      chk("busy_sat_one", 2, 64'(b_one), 64'd7);

      // randomized traffic: requests are held until the model grants them
      for (int d = 0; d < 3; d++)
         for (int k = 0; k < 3; k++) pend[d][k] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int d = 0; d < 3; d++) begin
            if (c > 0 && lastw[d] >= 0) pend[d][lastw[d]] = 0;
            for (int k = 0; k < n_u[d]; k++) begin
               if (!pend[d][k] && ($urandom_range(2) == 0)) begin
                  pend[d][k] = 1;
                  pin[d][k*W +: W] = W'($urandom);
               end
               vin[d][k] = pend[d][k];
            end
         end
         flush = ($urandom_range(7) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
